// File: rtl/ipu_move_ctrl.sv
// ipu_move_ctrl
// Front end of the tic-tac-toe input processing unit. It synchronizes and
// debounces the confirm button, samples the cell-select switches, checks the
// selected coordinate, and offers each accepted move to the processor as a
// level interrupt.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active low
//   confirm_btn  raw push-button, active high, asynchronous to clk
//   coord_sw     raw 4-bit cell-select switches
//   int_ack      interrupt acknowledge from the processor
//   ipu_int      move-available interrupt (level)
//   grid_coord   coordinate of the last accepted move
//   busy         a move is outstanding (FSM not in IDLE)
//   invalid      one-cycle pulse: press with an illegal coordinate
//   dropped      one-cycle pulse: press while a move is outstanding
//
// Handshake: ipu_int is a level request. ipu_int and grid_coord stay constant
// from the cycle ipu_int rises until int_ack is sampled high. ipu_int then
// falls on the next edge. A new move is not accepted until int_ack has been
// seen low again, so a held ack cannot acknowledge a move it never saw.
module ipu_move_ctrl #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 20,
   parameter int GRID_CELLS      = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       confirm_btn,
   input  logic [3:0] coord_sw,
   input  logic       int_ack,
   output logic       ipu_int,
   output logic [3:0] grid_coord,
   output logic       busy,
   output logic       invalid,
   output logic       dropped
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_INT     = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [4:0]       GRID_LIM = 5'(GRID_CELLS);

   logic             r_btn_s1, r_btn_s2;
   logic [3:0]       r_coord_s1, r_coord_s2;
   logic             r_stable, r_stable_d;
   logic [CNT_W-1:0] r_cnt;
   state_t           r_state;
   logic [3:0]       r_grid_coord;
   logic             r_invalid, r_dropped;

   state_t           w_state_nxt;
   logic             w_press;
   logic             w_coord_ok;
   logic             w_load_coord;
   logic             w_invalid_nxt;
   logic             w_dropped_nxt;

   // Two-flop synchronizers for the button and the switches
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_btn_s1   <= 1'b0;
         r_btn_s2   <= 1'b0;
         r_coord_s1 <= 4'd0;
         r_coord_s2 <= 4'd0;
      end else begin
         r_btn_s1   <= confirm_btn;
         r_btn_s2   <= r_btn_s1;
         r_coord_s1 <= coord_sw;
         r_coord_s2 <= r_coord_s1;
      end
   end

   // Debounce: the stable value flips only after the synchronized button has
   // disagreed with it for DEBOUNCE_CYCLES consecutive cycles; any agreement
   // restarts the count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stable   <= 1'b0;
         r_stable_d <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_stable_d <= r_stable;
         if (r_btn_s2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_stable <= r_btn_s2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // One press per debounced rising edge
   assign w_press    = r_stable & ~r_stable_d;
   assign w_coord_ok = ({1'b0, r_coord_s2} < GRID_LIM);

   // FSM: state register plus registered coordinate and status pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_grid_coord <= 4'd0;
         r_invalid    <= 1'b0;
         r_dropped    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_invalid <= w_invalid_nxt;
         r_dropped <= w_dropped_nxt;
         if (w_load_coord) begin
            r_grid_coord <= r_coord_s2;
         end
      end
   end

   // FSM: next state
   always_comb begin
      w_state_nxt   = r_state;
      w_load_coord  = 1'b0;
      w_invalid_nxt = 1'b0;
      w_dropped_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_press) begin
               if (w_coord_ok) begin
                  w_state_nxt  = ST_INT;
                  w_load_coord = 1'b1;
               end else begin
                  w_invalid_nxt = 1'b1;
               end
            end
         end
         ST_INT: begin
            // A press coinciding with the ack is dropped; the ack still counts
            if (int_ack) begin
               w_state_nxt = ST_RELEASE;
            end
            w_dropped_nxt = w_press;
         end
         ST_RELEASE: begin
            if (!int_ack) begin
               w_state_nxt = ST_IDLE;
            end
            w_dropped_nxt = w_press;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM: outputs
   always_comb begin
      ipu_int    = (r_state == ST_INT);
      busy       = (r_state != ST_IDLE);
      grid_coord = r_grid_coord;
      invalid    = r_invalid;
      dropped    = r_dropped;
   end

endmodule

// File: doc/ipu_move_ctrl.md
Name: ipu_move_ctrl

Overview:
- Input processing unit (IPU) front end for the tic-tac-toe game. Samples the raw confirm button and the 4-bit cell-select switches, then debounces and validates the move.
- Presents an accepted move to the processor as a level interrupt (ipu_int) with a stable grid_coord, and holds both until the processor returns int_ack.
- It is the initiator side of the proc ipu_int/int_ack/grid_coord interface and replaces the bench-driven interrupt stimulus.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive cycles the synchronized button must differ from its stable value before the stable value flips (use 4 in bench; board build overrides to 500000).
- CNT_W, 20, debounce counter width; must hold DEBOUNCE_CYCLES-1.
- GRID_CELLS, 9, number of legal cells; legal coordinates are 0..GRID_CELLS-1.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low (asserted when 0)
- confirm_btn  input  1  raw asynchronous push-button, active-high
- coord_sw  input  4  raw switch value selecting the cell
- int_ack  input  1  interrupt acknowledge from proc
- ipu_int  output  1  move-available interrupt to proc
- grid_coord  output  4  latched cell coordinate to proc
- busy  output  1  high while a move is outstanding (state != IDLE)
- invalid  output  1  one-cycle pulse: confirm pressed with an illegal coordinate
- dropped  output  1  one-cycle pulse: confirm pressed while busy

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; synchronizers, stable button, edge register and counter cleared; FSM goes to IDLE. Reset mid-INT drops ipu_int immediately.
- Synchronization: confirm_btn and coord_sw each pass through a 2-flop synchronizer (s1, s2).
- Debounce counter:
  - When s2 == stable, the counter is 0.
  - When s2 != stable, the counter increments.
  - When s2 != stable and counter == DEBOUNCE_CYCLES-1, stable <= s2 and the counter clears.
- Press detection: press = stable & ~stable_d, where stable_d is stable registered one cycle. Exactly one press per debounced rising edge. A held button gives one press. A glitch shorter than DEBOUNCE_CYCLES cycles gives none.
- Latency: if raw confirm rises before edge 1 and stays high, stable rises at edge DEBOUNCE_CYCLES+2 and ipu_int rises at edge DEBOUNCE_CYCLES+3.
- FSM states: IDLE, INT, RELEASE.
  - IDLE, press, synchronized coord < GRID_CELLS: grid_coord <= coord, ipu_int <= 1, go to INT.
  - IDLE, press, coord >= GRID_CELLS: invalid pulses for 1 cycle, stay in IDLE, grid_coord unchanged.
  - IDLE, int_ack high: ignored.
  - INT: ipu_int and grid_coord are held constant. When int_ack is sampled 1: ipu_int <= 0, go to RELEASE.
  - RELEASE: wait for int_ack == 0, then go to IDLE. This stops a held ack from satisfying the next move.
- Press while in INT or RELEASE: dropped pulses for 1 cycle; no state or grid_coord change. A press in the same cycle as an ack in INT is dropped and the ack is still processed.
- grid_coord keeps its last accepted value after the ack until the next accepted move.
- busy is combinational: state != IDLE.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, coord_sw=4'd2, raise confirm_btn before edge 1 and hold -> ipu_int=1 and grid_coord=2 from edge 7; busy=1; exactly one interrupt while held.
- From INT, pulse int_ack high 1 cycle -> ipu_int=0 the next edge; FSM returns to IDLE after ack low; grid_coord stays 2.
- Hold int_ack high 5 cycles, then make a new press with coord 5 -> press during RELEASE pulses dropped; press after ack low yields grid_coord=5, ipu_int=1.
- coord_sw=4'd11, press -> invalid one-cycle pulse, ipu_int stays 0, grid_coord unchanged.
- Confirm glitch high for 3 cycles -> no press, no interrupt; counter returns to 0.
- Assert rst=0 mid-INT between clock edges -> ipu_int, grid_coord and busy go to 0 immediately; after release a fresh press works normally.
